// File: rtl/execute.sv
// rtl/execute.sv - Y86-64 SEQ execute stage: ALU, condition codes, halt/retire state
module execute #(
  parameter int WORD = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      icode,
  input  logic [3:0]      ifun,
  input  logic            instructionValid,
  input  logic [WORD-1:0] valA,
  input  logic [WORD-1:0] valB,
  input  logic [WORD-1:0] valC,
  output logic [WORD-1:0] valE,
  output logic            cnd,
  output logic            zf,
  output logic            sf,
  output logic            of,
  output logic            halted,
  output logic [WORD-1:0] retired
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;

  localparam logic [WORD-1:0] STACK_STEP = WORD'(8);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            zf_q, zf_d;
  logic            sf_q, sf_d;
  logic            of_q, of_d;
  logic [WORD-1:0] retired_q, retired_d;

  logic [WORD-1:0] op_sum;
  logic [WORD-1:0] op_diff;
  logic [WORD-1:0] op_r;
  logic            op_ifun_ok;
  logic            op_zf, op_sf, op_of;
  logic [WORD-1:0] alu_r;
  logic            sf_xor_of;
  logic            cnd_c;
  logic            update_en;
  logic            cc_load;

  assign op_sum     = valB + valA;
  assign op_diff    = valB - valA;
  assign op_ifun_ok = (ifun <= F_XOR);

  // OPq result and the flags it would produce if this instruction loads the CC
  always_comb begin
    op_r = '0;
    case (ifun)
      F_ADD:   op_r = op_sum;
      F_SUB:   op_r = op_diff;
      F_AND:   op_r = valB & valA;
      F_XOR:   op_r = valB ^ valA;
      default: op_r = '0;
    endcase
    op_zf = (op_r == '0);
    op_sf = op_r[WORD-1];
    op_of = 1'b0;
    if (ifun == F_ADD) begin
      op_of = (valA[WORD-1] == valB[WORD-1]) && (op_r[WORD-1] != valB[WORD-1]);
    end else if (ifun == F_SUB) begin
      op_of = (valA[WORD-1] != valB[WORD-1]) && (op_r[WORD-1] != valB[WORD-1]);
    end
  end

  // ALU result selected by instruction class; unknown instructions yield zero
  always_comb begin
    alu_r = '0;
    case (icode)
      I_CMOV:           alu_r = valA;
      I_IRMOVQ:         alu_r = valC;
      I_RMMOVQ,
      I_MRMOVQ:         alu_r = valB + valC;
      I_OPQ:            alu_r = op_r;
      I_CALL,
      I_PUSHQ:          alu_r = valB - STACK_STEP;
      I_RET,
      I_POPQ:           alu_r = valB + STACK_STEP;
      default:          alu_r = '0;
    endcase
  end

  assign sf_xor_of = sf_q ^ of_q;

  // Branch/move condition evaluated from the registered (pre-edge) flags
  always_comb begin
    cnd_c = 1'b0;
    if (icode == I_CMOV || icode == I_JXX) begin
      case (ifun)
        4'h0:    cnd_c = 1'b1;
        4'h1:    cnd_c = sf_xor_of | zf_q;
        4'h2:    cnd_c = sf_xor_of;
        4'h3:    cnd_c = zf_q;
        4'h4:    cnd_c = ~zf_q;
        4'h5:    cnd_c = ~sf_xor_of;
        4'h6:    cnd_c = ~sf_xor_of & ~zf_q;
        default: cnd_c = 1'b0;
      endcase
    end
  end

  // Only valid instructions issued while running may change architectural state
  assign update_en = instructionValid && (state_q == ST_RUN);
  assign cc_load   = update_en && (icode == I_OPQ) && op_ifun_ok;

  // Next-state: halt transition, CC load and retire counter
  always_comb begin
    state_d   = state_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    of_d      = of_q;
    retired_d = retired_q;
    case (state_q)
      ST_RUN: begin
        if (instructionValid && icode == I_HALT) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
    if (cc_load) begin
      zf_d = op_zf;
      sf_d = op_sf;
      of_d = op_of;
    end
    if (update_en) begin
      retired_d = retired_q + WORD'(1);
    end
  end

  // State registers; reset forces the architectural reset values immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      zf_q      <= 1'b1;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
      retired_q <= retired_d;
    end
  end

  assign valE    = alu_r;
  assign cnd     = cnd_c;
  assign zf      = zf_q;
  assign sf      = sf_q;
  assign of      = of_q;
  assign halted  = (state_q == ST_HALTED);
  assign retired = retired_q;

endmodule

// File: doc/execute.md
# execute

Execute stage of the Y86-64 SEQ processor, directly downstream of decode. It consumes decoded `icode`, `ifun`, `valA`, `valB` and `valC`, and computes the ALU result `valE` and the branch/move condition `cnd`. Both feed memory and writeback. The block owns the condition-code register (ZF/SF/OF), a halted flag and a retired-instruction counter.

## Interface
Parameters:
- `WORD`, 64: datapath width. Only 64 is supported.

Ports:
- `clk`  in  1  processor clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `icode`  in  4  instruction code from fetch/decode.
- `ifun`  in  4  function code.
- `instructionValid`  in  1  current instruction is valid; gates every state update.
- `valA`  in  64  register operand A from decode.
- `valB`  in  64  register operand B from decode (%rsp for stack instructions).
- `valC`  in  64  immediate or displacement from fetch.
- `valE`  out  64  ALU result (combinational).
- `cnd`  out  1  condition result for cmovXX/jXX (combinational).
- `zf`, `sf`, `of`  out  1 each  condition-code register outputs.
- `halted`  out  1  a valid halt has executed.
- `retired`  out  64  count of valid instructions retired since reset.

## Operation
ALU, combinational, modulo 2^64:
- 2 cmovXX: valE = valA + 0.
- 3 irmovq: valE = valC + 0.
- 4 rmmovq, 5 mrmovq: valE = valB + valC.
- 6 OPq: valE = valB op valA.
  - ifun 0 add, 1 sub (valB − valA), 2 and, 3 xor.
  - ifun > 3: valE = 0.
- 8 call, 10 pushq: valE = valB − 8.
- 9 ret, 11 popq: valE = valB + 8.
- 0 halt, 1 nop, 7 jXX, and any other icode: valE = 0.

Condition codes, computed from the OPq result r with operands a = valA and b = valB:
- ZF = (r == 0).
- SF = r[63].
- OF for add: (a[63] == b[63]) && (r[63] != b[63]).
- OF for sub: (a[63] != b[63]) && (r[63] != b[63]).
- OF for and/xor: 0.

CC register update:
- Loads the three flags only when icode = 6, ifun ≤ 3, instructionValid = 1 and halted = 0.
- Holds its value otherwise.

cnd:
- Driven only for icode 2 or 7, from the registered CC (pre-edge values).
- ifun 0 always → 1; 1 le → (SF^OF)|ZF; 2 l → SF^OF; 3 e → ZF; 4 ne → ~ZF; 5 ge → ~(SF^OF); 6 g → ~(SF^OF)&~ZF; ifun > 6 → 0.
- All other icodes: cnd = 0.

Halt and retire state machine, two states:
- RUN → HALTED on a rising edge with icode = 0 and instructionValid = 1.
- HALTED is left only by reset.
- In HALTED: CC and `retired` are frozen; valE and cnd still evaluate combinationally.
- `retired` increments by 1 on each edge in RUN with instructionValid = 1, including the halt instruction itself.
- `retired` wraps from 2^64−1 to 0.

## Timing
- Reset values: zf = 1, sf = 0, of = 0, halted = 0, retired = 0, state = RUN.
- Reset takes effect asynchronously, including mid-cycle; reset overrides every simultaneous update.
- valE and cnd have zero latency: they are valid in the same cycle as their inputs and are consumed by the writeback edge.
- CC, halted and retired update on the same rising edge as register writeback.
- An OPq's new flags become visible at `zf`/`sf`/`of` after that edge. Only the next instruction's cnd sees them.
- With instructionValid = 0: no state change; valE and cnd still follow the inputs.
- Invalid OPq ifun (> 3): valE = 0, CC unchanged, retired still increments.

## Test plan
- Reset, then icode 7, ifun 3 → zf = 1, sf = 0, of = 0, cnd = 1, halted = 0, retired = 0.
- OPq add, valA = 0x7FFF_FFFF_FFFF_FFFF, valB = 1 → valE = 0x8000_0000_0000_0000. After the edge: zf = 0, sf = 1, of = 1. Then jl (ifun 2) → cnd = 0; jge (ifun 5) → cnd = 1.
- OPq sub, valA = 5, valB = 5 → valE = 0; after the edge zf = 1, sf = 0, of = 0. Then cmov ifun 3 with valA = 0x2A → valE = 0x2A, cnd = 1. Then jne → cnd = 0.
- Stack and address instructions, each leaving CC unchanged and retired +1:
  - pushq, valB = 254 → valE = 246.
  - popq, valB = 246 → valE = 254.
  - rmmovq, valB = 0x100, valC = 0x18 → valE = 0x118.
  - irmovq, valC = 9 → valE = 9.
- OPq with instructionValid = 0 → no CC or retired change. Then a valid halt → halted = 1, retired +1. A following valid OPq sub with valA = 1, valB = 0 → valE = 0xFFFF_FFFF_FFFF_FFFF, but flags and retired stay frozen.
- Set sf = 1 via OPq, then assert reset between edges → zf = 1, sf = 0, of = 0, halted = 0, retired = 0 before the next edge.
